avst_to_avmm_fifo: RTL and testbench

AVST_TO_AVMM_FIFO -- requirements
Module: avst_to_avmm_fifo

---
 rtl/avst_fifo_pkg.sv | 21 ++
 rtl/sc_fifo_core.sv | 75 +++++++
 rtl/avst_to_avmm_fifo.sv | 147 ++++++++++++++
 tb/tb_avst_to_avmm_fifo.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avst_fifo_pkg.sv
// Shared register map for the Avalon-ST to Avalon-MM FIFO bridge:
// register addresses, status bit positions and control bit positions.
package avst_fifo_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_LEVEL  = 2'd1,
        REG_THRESH = 2'd2,
        REG_CTRL   = 2'd3
    } reg_addr_e;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_IRQ_PEND = 2;
    localparam int STAT_IRQ_EN   = 3;
    localparam int STATUS_W      = 4;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/sc_fifo_core.sv
// Single-clock FIFO core with show-ahead head word, occupancy level and flush.
// Pointers wrap naturally because DEPTH is a power of two.
module sc_fifo_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset; clearing the pointers discards its contents.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem[rd_ptr_q];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));

endmodule

// File: rtl/avst_to_avmm_fifo.sv
// Avalon-ST sink feeding a FIFO that is drained through a small Avalon-MM slave
// register map, with a level-threshold interrupt.
module avst_to_avmm_fifo
    import avst_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic [1:0]        mm_address,
    input  logic              mm_read,
    input  logic              mm_write,
    input  logic [31:0]       mm_writedata,
    output logic [DATA_W-1:0] mm_readdata,
    output logic              mm_waitrequest,
    output logic              irq
);

    logic [DATA_W-1:0] head_data;
    logic [LVL_W-1:0]  level;
    logic              empty;
    logic              full;

    logic [LVL_W-1:0]  thresh_q, thresh_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_pend_q, irq_pend_d;
    logic              ready_en_q;

    reg_addr_e         addr;
    logic              rd_data;
    logic              wr_thresh;
    logic              wr_ctrl;
    logic              flush;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0]   level_ext;
    logic [DATA_W-1:0]   thresh_ext;
    logic [STATUS_W-1:0] status;
    logic                unused_wdata;

    assign addr = reg_addr_e'(mm_address);

    always_comb begin
        rd_data        = mm_read && (addr == REG_DATA);
        wr_thresh      = mm_write && (addr == REG_THRESH);
        wr_ctrl        = mm_write && (addr == REG_CTRL);
        flush          = wr_ctrl && mm_writedata[CTRL_FLUSH];
        // ready_en_q keeps the sink closed during reset and until the first edge after it.
        sink_ready     = ready_en_q && !full && !flush;
        push           = sink_valid && sink_ready;
        pop            = rd_data && !empty && !flush;
        mm_waitrequest = rd_data && empty;
    end

    sc_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (sink_data),
        .head_o  (head_data),
        .level_o (level),
        .empty_o (empty),
        .full_o  (full)
    );

    always_comb begin
        thresh_d   = wr_thresh ? mm_writedata[LVL_W-1:0] : thresh_q;
        irq_en_d   = wr_ctrl ? mm_writedata[CTRL_IRQ_EN] : irq_en_q;
        irq_pend_d = irq_pend_q;
        // Clearing takes priority so software can acknowledge even while still above threshold.
        if (wr_thresh || flush) begin
            irq_pend_d = 1'b0;
        end else if ((thresh_q != '0) && (level >= thresh_q)) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            thresh_q   <= '0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            thresh_q   <= thresh_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            ready_en_q <= 1'b1;
        end
    end

    assign irq = irq_en_q && irq_pend_q;

    // Zero-extend (or truncate, for very narrow data) the level-width registers.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ext
            if (gi < LVL_W) begin : g_bit
                assign level_ext[gi]  = level[gi];
                assign thresh_ext[gi] = thresh_q[gi];
            end else begin : g_zero
                assign level_ext[gi]  = 1'b0;
                assign thresh_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        status                = '0;
        status[STAT_EMPTY]    = empty;
        status[STAT_FULL]     = full;
        status[STAT_IRQ_PEND] = irq_pend_q;
        status[STAT_IRQ_EN]   = irq_en_q;
    end

    always_comb begin
        mm_readdata = '0;
        if (mm_read) begin
            case (addr)
                REG_DATA: begin
                    if (!empty) begin
                        mm_readdata = head_data;
                    end
                end
                REG_LEVEL:  mm_readdata = level_ext;
                REG_THRESH: mm_readdata = thresh_ext;
                REG_CTRL:   mm_readdata[STATUS_W-1:0] = status;
                default:    mm_readdata = '0;
            endcase
        end
    end

    assign unused_wdata = ^mm_writedata[31:LVL_W];

endmodule

// File: tb/tb_avst_to_avmm_fifo.sv
// Directed bench for avst_to_avmm_fifo: accepted sink words go into a scoreboard
// queue and are popped and compared as addr-0 reads complete.
module tb_avst_to_avmm_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] sink_data;
    logic              sink_valid;
    logic              sink_ready;
    logic [1:0]        mm_address;
    logic              mm_read;
    logic              mm_write;
    logic [31:0]       mm_writedata;
    logic [DATA_W-1:0] mm_readdata;
    logic              mm_waitrequest;
    logic              irq;

    logic [31:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    avst_to_avmm_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .sink_data      (sink_data),
        .sink_valid     (sink_valid),
        .sink_ready     (sink_ready),
        .mm_address     (mm_address),
        .mm_read        (mm_read),
        .mm_write       (mm_write),
        .mm_writedata   (mm_writedata),
        .mm_readdata    (mm_readdata),
        .mm_waitrequest (mm_waitrequest),
        .irq            (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sb_pop();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 'x;
    endfunction

    task automatic set_idle();
        sink_valid   = 1'b0;
        sink_data    = '0;
        mm_read      = 1'b0;
        mm_write     = 1'b0;
        mm_address   = 2'd0;
        mm_writedata = '0;
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clock);
        set_idle();
        sink_valid = 1'b1;
        sink_data  = d;
        #1;
        check("push_ready", sink_ready, 1);
        if (sink_ready) exp_q.push_back(d);
        @(posedge clock);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        set_idle();
        mm_write     = 1'b1;
        mm_address   = a;
        mm_writedata = d;
        #1;
        check("write_waitreq", mm_waitrequest, 0);
        @(posedge clock);
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clock);
        set_idle();
        mm_read    = 1'b1;
        mm_address = a;
        #1;
        while (mm_waitrequest && waits < 20) begin
            waits++;
            @(posedge clock);
            @(negedge clock);
            #1;
        end
        if (mm_waitrequest) check("read_timeout", mm_waitrequest, 0);
        d = mm_readdata;
        @(posedge clock);
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int w;
        reg_read(a, d, w);
        check(tag, d, exp);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        int w;
        logic [31:0] e;
        reg_read(2'd0, d, w);
        e = sb_pop();
        check({tag, "_waits"}, w, 0);
        check(tag, d, e);
    endtask

    initial begin
        int waits;
        logic [31:0] e;

        set_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);

        // Reset state
        @(negedge clock);
        #1;
        check("rst_sink_ready", sink_ready, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata_idle", mm_readdata, 0);
        mm_read    = 1'b1;
        mm_address = 2'd0;
        #1;
        check("rst_waitreq", mm_waitrequest, 1);
        mm_address = 2'd1;
        #1;
        check("rst_level", mm_readdata, 0);
        set_idle();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", sink_ready, 0);
        @(posedge clock);
        #1;
        check("ready_after_edge", sink_ready, 1);

        // Basic push/pop ordering
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        @(negedge clock);
        set_idle();
        #1;
        check("idle_rdata_zero", mm_readdata, 0);
        @(posedge clock);
        check_reg("level_3", 2'd1, 3);
        pop_check("pop_basic");
        pop_check("pop_basic");
        pop_check("pop_basic");
        check_reg("level_0", 2'd1, 0);

        // Read stalls on empty until a push lands
        waits = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            set_idle();
            mm_read    = 1'b1;
            mm_address = 2'd0;
            if (c == 5) begin
                sink_valid = 1'b1;
                sink_data  = 32'hA5;
            end
            #1;
            if (mm_waitrequest) waits++;
            if (c == 5 && sink_ready) exp_q.push_back(32'hA5);
            @(posedge clock);
        end
        check("stall_cycles", waits, 6);
        @(negedge clock);
        set_idle();
        mm_read    = 1'b1;
        mm_address = 2'd0;
        #1;
        check("stall_done_waitreq", mm_waitrequest, 0);
        e = sb_pop();
        check("stall_data", mm_readdata, e);
        @(posedge clock);
        check_reg("stall_level", 2'd1, 0);

        // Fill to full, pop one while a word is held on the sink
        for (int i = 0; i < DEPTH; i++) push_word(32'h100 + i);
        check_reg("full_level", 2'd1, DEPTH);
        @(negedge clock);
        set_idle();
        sink_valid = 1'b1;
        sink_data  = 32'hBEEF;
        #1;
        check("full_ready_low", sink_ready, 0);
        @(posedge clock);
        check_reg("full_status", 2'd3, 32'h2);
        @(negedge clock);
        set_idle();
        mm_read    = 1'b1;
        mm_address = 2'd0;
        sink_valid = 1'b1;
        sink_data  = 32'hBEEF;
        #1;
        check("full_pop_ready", sink_ready, 0);
        check("full_pop_waitreq", mm_waitrequest, 0);
        e = sb_pop();
        check("full_pop_data", mm_readdata, e);
        @(posedge clock);
        @(negedge clock);
        set_idle();
        sink_valid = 1'b1;
        sink_data  = 32'hBEEF;
        #1;
        check("refill_ready", sink_ready, 1);
        if (sink_ready) exp_q.push_back(32'hBEEF);
        @(posedge clock);
        check_reg("refill_level", 2'd1, DEPTH);
        for (int i = 0; i < DEPTH; i++) pop_check("drain_full");
        check_reg("drained_status", 2'd3, 32'h1);

        // Threshold interrupt
        reg_write(2'd2, 32'd8);
        reg_write(2'd3, 32'h2);
        check_reg("thresh_read", 2'd2, 8);
        for (int i = 0; i < 8; i++) push_word(32'h200 + i);
        @(negedge clock);
        set_idle();
        #1;
        check("irq_not_yet", irq, 0);
        @(posedge clock);
        @(negedge clock);
        #1;
        check("irq_set", irq, 1);
        @(posedge clock);
        check_reg("irq_status", 2'd3, 32'hC);
        reg_write(2'd2, 32'd0);
        @(negedge clock);
        set_idle();
        #1;
        check("irq_cleared", irq, 0);
        @(posedge clock);
        for (int i = 0; i < 8; i++) pop_check("drain_irq");

        // Flush while the sink is offering data
        for (int i = 0; i < 20; i++) push_word(32'h300 + i);
        check_reg("pre_flush_level", 2'd1, 20);
        @(negedge clock);
        set_idle();
        mm_write     = 1'b1;
        mm_address   = 2'd3;
        mm_writedata = 32'h1;
        sink_valid   = 1'b1;
        sink_data    = 32'h77;
        #1;
        check("flush_ready_low", sink_ready, 0);
        @(posedge clock);
        exp_q.delete();
        check_reg("flush_level", 2'd1, 0);
        check_reg("flush_status", 2'd3, 32'h1);

        // Reset in the middle of operation
        for (int i = 0; i < 10; i++) push_word(32'h400 + i);
        reg_write(2'd2, 32'd5);
        reg_write(2'd3, 32'h2);
        @(negedge clock);
        set_idle();
        #1;
        check("pre_reset_irq", irq, 1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_ready", sink_ready, 0);
        check("mid_rst_irq", irq, 0);
        mm_read    = 1'b1;
        mm_address = 2'd1;
        #1;
        check("mid_rst_level", mm_readdata, 0);
        @(posedge clock);
        @(negedge clock);
        #1;
        check("mid_rst_ready_hold", sink_ready, 0);
        set_idle();
        reset_n = 1'b1;
        #1;
        check("rel_ready_before_edge", sink_ready, 0);
        @(posedge clock);
        #1;
        check("rel_ready_after_edge", sink_ready, 1);
        check_reg("post_rst_level", 2'd1, 0);
        check_reg("post_rst_thresh", 2'd2, 0);
        check_reg("post_rst_status", 2'd3, 32'h1);
        push_word(32'h5A);
        pop_check("post_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
